quadrature_decoder: RTL and testbench

//  Decodes a 2-phase quadrature signal pair (A/B) from an incremental encoder into

---
 rtl/qdec_pkg.sv | 51 +++++
 rtl/qdec_sync.sv | 67 ++++++
 rtl/quadrature_decoder.sv | 131 +++++++++++++
 tb/tb_quadrature_decoder.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/qdec_pkg.sv
// Shared types and decode helpers for the quadrature decoder.
// Build option: define QDEC_FILTER_EN to insert a stability (glitch) filter
// after each phase synchronizer.
package qdec_pkg;

`ifdef QDEC_FILTER_EN
  localparam bit FILTER_EN = 1'b1;
`else
  localparam bit FILTER_EN = 1'b0;
`endif

  typedef enum logic {
    S_INIT  = 1'b0,
    S_TRACK = 1'b1
  } qdec_state_e;

  // Phase codes are {A,B}
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  // Up sequence is 00 -> 10 -> 11 -> 01 -> 00
  function automatic logic is_up(input logic [1:0] prev, input logic [1:0] cur);
    logic r;
    r = 1'b0;
    case (prev)
      PH_00:   r = (cur == PH_10);
      PH_10:   r = (cur == PH_11);
      PH_11:   r = (cur == PH_01);
      default: r = (cur == PH_00);
    endcase
    return r;
  endfunction

  // Down sequence is the reverse walk: 00 -> 01 -> 11 -> 10 -> 00
  function automatic logic is_down(input logic [1:0] prev, input logic [1:0] cur);
    return is_up(cur, prev);
  endfunction

  // Both phases changing at once cannot be resolved into a direction
  function automatic logic is_illegal(input logic [1:0] prev, input logic [1:0] cur);
    return ((prev ^ cur) == 2'b11);
  endfunction

  // Cycles the FSM must let the input pipeline settle before trusting it
  function automatic int init_wait(input int sync_stages, input int filter_len);
    return FILTER_EN ? (sync_stages + filter_len) : sync_stages;
  endfunction

endpackage

// File: rtl/qdec_sync.sv
// One phase input: multi-stage synchronizer, optionally followed by a
// stability filter when QDEC_FILTER_EN is defined.
module qdec_sync
  import qdec_pkg::*;
#(
  parameter int SYNC_STAGES = 2
`ifdef QDEC_FILTER_EN
  , parameter int FILTER_LEN = 4
`endif
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_in,
  output logic q_out
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [SYNC_STAGES-1:0] sync_d;

  // Shift the raw pin into the synchronizer chain
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], d_in};
  end

  // Synchronizer flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) sync_q <= '0;
    else          sync_q <= sync_d;
  end

`ifdef QDEC_FILTER_EN
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);

  logic          filt_q, filt_d;
  logic [FW-1:0] cnt_q, cnt_d;

  // Accept a new level only after it has been seen FILTER_LEN cycles in a row
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync_q[SYNC_STAGES-1] != filt_q) begin
      if (cnt_q == FILT_LAST) begin
        filt_d = sync_q[SYNC_STAGES-1];
      end else begin
        cnt_d = cnt_q + FW'(1);
      end
    end
  end

  // Filter state flops
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign q_out = filt_q;
`else
  assign q_out = sync_q[SYNC_STAGES-1];
`endif

endmodule

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: turns encoder phases A/B into step/dir pulses and a
// wrapping up/down position count, flagging illegal double-phase jumps.
// Build option: QDEC_FILTER_EN adds a per-phase glitch filter.
module quadrature_decoder
  import qdec_pkg::*;
#(
  parameter int BITS        = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILTER_LEN  = 4
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            a_in,
  input  logic            b_in,
  input  logic            clear,
  input  logic            error_clr,
  output logic [BITS-1:0] position,
  output logic            dir,
  output logic            step,
  output logic            error
);

  localparam int INIT_WAIT = init_wait(SYNC_STAGES, FILTER_LEN);
  localparam int CNT_W     = $clog2(INIT_WAIT + 1);
  localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_WAIT);

  logic a_s, b_s;
  logic [1:0] cur;

  qdec_state_e      state_q, state_d;
  logic [CNT_W-1:0] init_cnt_q, init_cnt_d;
  logic [1:0]       prev_q, prev_d;
  logic [BITS-1:0]  position_q, position_d;
  logic             dir_q, dir_d;
  logic             step_q, step_d;
  logic             error_q, error_d;

  qdec_sync #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_FILTER_EN
    , .FILTER_LEN(FILTER_LEN)
`endif
  ) u_sync_a (
    .clk    (clk),
    .reset_n(reset_n),
    .d_in   (a_in),
    .q_out  (a_s)
  );

  qdec_sync #(
    .SYNC_STAGES(SYNC_STAGES)
`ifdef QDEC_FILTER_EN
    , .FILTER_LEN(FILTER_LEN)
`endif
  ) u_sync_b (
    .clk    (clk),
    .reset_n(reset_n),
    .d_in   (b_in),
    .q_out  (b_s)
  );

  assign cur = {a_s, b_s};

  // Next state: settle pipeline, then decode each phase change into step/error
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    prev_d     = prev_q;
    position_d = position_q;
    dir_d      = dir_q;
    step_d     = 1'b0;
    error_d    = error_q;

    if (error_clr) error_d = 1'b0;

    case (state_q)
      S_INIT: begin
        if (init_cnt_q == INIT_LAST) begin
          prev_d     = cur;
          init_cnt_d = '0;
          state_d    = S_TRACK;
        end else begin
          init_cnt_d = init_cnt_q + CNT_W'(1);
        end
      end
      default: begin
        prev_d = cur;
        if (is_up(prev_q, cur)) begin
          step_d     = 1'b1;
          dir_d      = 1'b1;
          position_d = position_q + BITS'(1);
        end else if (is_down(prev_q, cur)) begin
          step_d     = 1'b1;
          dir_d      = 1'b0;
          position_d = position_q - BITS'(1);
        end else if (is_illegal(prev_q, cur)) begin
          error_d = 1'b1;
        end
      end
    endcase

    if (clear) position_d = '0;
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      prev_q     <= PH_00;
      position_q <= '0;
      dir_q      <= 1'b0;
      step_q     <= 1'b0;
      error_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      prev_q     <= prev_d;
      position_q <= position_d;
      dir_q      <= dir_d;
      step_q     <= step_d;
      error_q    <= error_d;
    end
  end

  assign position = position_q;
  assign dir      = dir_q;
  assign step     = step_q;
  assign error    = error_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Directed testbench for quadrature_decoder with default parameters.
// The filter scenario runs only when QDEC_FILTER_EN is defined.
module tb_quadrature_decoder;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        a_in = 1'b0;
  logic        b_in = 1'b0;
  logic        clear = 1'b0;
  logic        error_clr = 1'b0;
  logic [15:0] position;
  logic        dir;
  logic        step;
  logic        error;

  int check_count = 0;
  int pass_count  = 0;
  int step_cnt    = 0;
  int base;

  logic [1:0] up_seq[4]   = '{2'b10, 2'b11, 2'b01, 2'b00};
  logic [1:0] down_seq[4] = '{2'b01, 2'b11, 2'b10, 2'b00};

  quadrature_decoder dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .a_in     (a_in),
    .b_in     (b_in),
    .clear    (clear),
    .error_clr(error_clr),
    .position (position),
    .dir      (dir),
    .step     (step),
    .error    (error)
  );

  always #5 clk = ~clk;

  // Count step pulses, sampled mid-cycle
  always @(negedge clk) begin
    if (step) step_cnt++;
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_count++;
    if (got === exp) pass_count++;
    else $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Drive a phase pair at a falling edge, then let it settle for 10 cycles
  task automatic applyStimulus(input logic [1:0] ph);
    @(negedge clk);
    a_in = ph[1];
    b_in = ph[0];
    repeat (10) @(negedge clk);
  endtask

  initial begin
    // Reset with A=B=0
    repeat (3) @(negedge clk);
    checkOutput("reset_pos", 32'(position), 32'h0);
    checkOutput("reset_dir", 32'(dir), 32'h0);
    checkOutput("reset_step", 32'(step), 32'h0);
    checkOutput("reset_err", 32'(error), 32'h0);
    reset_n = 1'b1;
    repeat (10) @(negedge clk);

    // Four full up cycles
    base = step_cnt;
    for (int c = 0; c < 4; c++)
      for (int i = 0; i < 4; i++) applyStimulus(up_seq[i]);
    checkOutput("up_pos", 32'(position), 32'd16);
    checkOutput("up_dir", 32'(dir), 32'h1);
    checkOutput("up_steps", 32'(step_cnt - base), 32'd16);
    checkOutput("up_err", 32'(error), 32'h0);

    // Twenty down edges: 16 - 20 wraps to 0xFFFC
    base = step_cnt;
    for (int i = 0; i < 20; i++) applyStimulus(down_seq[i % 4]);
    checkOutput("down_pos", 32'(position), 32'h0000FFFC);
    checkOutput("down_dir", 32'(dir), 32'h0);
    checkOutput("down_steps", 32'(step_cnt - base), 32'd20);

    // Clear, then wrap below zero and back up through zero
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checkOutput("clear_pos", 32'(position), 32'h0);
    applyStimulus(2'b01);
    checkOutput("wrap_down", 32'(position), 32'h0000FFFF);
    applyStimulus(2'b00);
    checkOutput("wrap_up", 32'(position), 32'h0);

    // Illegal 00 -> 11 jump
    base = step_cnt;
    applyStimulus(2'b11);
    checkOutput("ill_err", 32'(error), 32'h1);
    checkOutput("ill_pos", 32'(position), 32'h0);
    checkOutput("ill_steps", 32'(step_cnt - base), 32'd0);
    @(negedge clk); error_clr = 1'b1;
    @(negedge clk); error_clr = 1'b0;
    checkOutput("errclr", 32'(error), 32'h0);
    applyStimulus(2'b01);
    checkOutput("after_ill_pos", 32'(position), 32'h1);

    // Illegal 01 -> 10 jump with error_clr on the detection cycle
    base = step_cnt;
    @(negedge clk); a_in = 1'b1; b_in = 1'b0;
    @(negedge clk);
    @(negedge clk); error_clr = 1'b1;
    @(negedge clk); error_clr = 1'b0;
    checkOutput("set_wins", 32'(error), 32'h1);
    repeat (8) @(negedge clk);
    checkOutput("set_wins_pos", 32'(position), 32'h1);
    checkOutput("set_wins_steps", 32'(step_cnt - base), 32'd0);

    // Asynchronous reset mid-cycle, pins held at 11
    @(negedge clk);
    a_in = 1'b1; b_in = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    checkOutput("async_rst_err", 32'(error), 32'h0);
    checkOutput("async_rst_dir", 32'(dir), 32'h0);
    checkOutput("async_rst_pos", 32'(position), 32'h0);
    repeat (2) @(negedge clk);
    base = step_cnt;
    reset_n = 1'b1;
    repeat (12) @(negedge clk);
    checkOutput("init_steps", 32'(step_cnt - base), 32'd0);
    checkOutput("init_err", 32'(error), 32'h0);
    applyStimulus(2'b01);
    checkOutput("init_up_pos", 32'(position), 32'h1);
    checkOutput("init_up_dir", 32'(dir), 32'h1);

    // Up step 01 -> 00 with clear on the update cycle; also checks latency
    @(negedge clk); a_in = 1'b0; b_in = 1'b0;
    @(negedge clk);
    checkOutput("lat_early", 32'(step), 32'h0);
    @(negedge clk); clear = 1'b1;
    @(negedge clk); clear = 1'b0;
    checkOutput("clr_step", 32'(step), 32'h1);
    checkOutput("clr_pos", 32'(position), 32'h0);
    checkOutput("clr_dir", 32'(dir), 32'h1);
    repeat (8) @(negedge clk);

`ifdef QDEC_FILTER_EN
    // Short glitch on A is rejected
    base = step_cnt;
    @(negedge clk); a_in = 1'b1;
    repeat (2) @(negedge clk); a_in = 1'b0;
    repeat (12) @(negedge clk);
    checkOutput("glitch_steps", 32'(step_cnt - base), 32'd0);
    checkOutput("glitch_pos", 32'(position), 32'h0);
    // A held high is accepted with SYNC_STAGES+FILTER_LEN+1 edges latency
    a_in = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("filt_early", 32'(step), 32'h0);
    @(negedge clk);
    checkOutput("filt_step", 32'(step), 32'h1);
    checkOutput("filt_pos", 32'(position), 32'h1);
    repeat (4) @(negedge clk);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
